// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte queue placed directly in front of a UART transmitter. System-side bytes
// arrive on a valid/ready handshake and are buffered in a DEPTH-entry FIFO.
// A small launcher FSM hands one byte at a time to the transmitter through a
// tx_start / tx_data / tx_busy interface. It never pulses tx_start while a
// frame is in flight. It flags a transmitter that fails to raise tx_busy
// within BUSY_TIMEOUT cycles of a launch.
//
// Optional feature (macro UART_TXQ_PAUSE_EN):
//   When defined, an extra input tx_pause holds the launcher in IDLE.
//   Frames already launched still complete, and pushes are still accepted.
//   When undefined, the port does not exist and IDLE launches whenever the
//   queue is non-empty.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   in_valid  in   system byte valid
//   in_data   in   [7:0] system byte
//   in_ready  out  FIFO can accept (not full)
//   count     out  [ADDR_W:0] bytes currently queued, 0..DEPTH
//   tx_start  out  one-cycle launch pulse to the transmitter
//   tx_data   out  [7:0] byte to the transmitter, held until the next launch
//   tx_busy   in   transmitter busy
//   tx_pause  in   (UART_TXQ_PAUSE_EN only) inhibit new launches
//   overflow  out  sticky: write attempted while full
//   timeout   out  sticky: tx_busy did not rise within BUSY_TIMEOUT cycles
//   err_clr   in   clears overflow and timeout; a same-cycle set wins
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 8,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W:0]   count,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
`ifdef UART_TXQ_PAUSE_EN
  input  logic              tx_pause,
`endif
  output logic              overflow,
  output logic              timeout,
  input  logic              err_clr
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Storage: no reset, so it can map onto block RAM. The single read port
  // feeds tx_data_q, which acts as the registered read.
  logic [7:0]        mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        tx_data_q;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;

  logic              full;
  logic              push;
  logic              pop;
  logic              tmo_evt;
  logic              launch_ok;

  // in_ready is derived from the registered count only. A pop in the same
  // cycle does not open a slot, so a write to a full FIFO is always rejected.
  assign full = (count_q == FULL_CNT);
  assign push = in_valid && !full;

`ifdef UART_TXQ_PAUSE_EN
  assign launch_ok = !tx_pause;
`else
  assign launch_ok = 1'b1;
`endif

  // Launcher FSM: next state, pop request and timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    tmo_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && launch_ok) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        timer_d = TMR_LOAD;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == '0) begin
          // The transmitter never acknowledged: drop the byte, do not retry.
          tmo_evt = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set has priority over clear so an event coinciding with err_clr is
    // never lost.
    overflow_d = (overflow_q && !err_clr) || (in_valid && full);
    timeout_d  = (timeout_q  && !err_clr) || tmo_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      // Captured on the IDLE->START edge and held through the whole frame.
      if (pop) begin
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready = !full;
  assign count    = count_q;
  assign tx_start = (state_q == START);
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo (DEPTH=16, BUSY_TIMEOUT=8).
// Accepted bytes are pushed to a scoreboard queue when they are driven.
// A monitor pops one entry per tx_start and compares it with tx_data.
// A simple transmitter model raises tx_busy one cycle after tx_start and
// holds it for busy_len cycles. Outputs are sampled on the falling edge.
// Inputs change at the falling edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [4:0] count;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       overflow;
  logic       timeout;
  logic       err_clr = 1'b0;
`ifdef UART_TXQ_PAUSE_EN
  logic       tx_pause = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] sb[$];
  int  start_cnt = 0;
  int  last_busy_cyc = 0;
  bit  seen_busy = 1'b0;
  bit  prev_start = 1'b0;
  logic [7:0] mon_exp;

  int  busy_len = 20;
  bit  auto_busy = 1'b1;

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .count    (count),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
`ifdef UART_TXQ_PAUSE_EN
    .tx_pause (tx_pause),
`endif
    .overflow (overflow),
    .timeout  (timeout),
    .err_clr  (err_clr)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy from the cycle after tx_start, for busy_len cycles.
  initial begin
    int len;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && auto_busy) begin
        len = busy_len;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: one line per launched frame.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        start_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_start: tx_data=%02h launched, no byte expected", tx_data);
        end else begin
          mon_exp = sb.pop_front();
          if (tx_data !== mon_exp) begin
            errors++;
            $display("FAIL sb_data: tx_data=%02h, expected %02h", tx_data, mon_exp);
          end else begin
            $display("frame %0d: tx_data=%02h at cycle %0d", start_cnt, tx_data, cyc);
          end
        end
        checks++;
        if (tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL start_while_busy: tx_busy=%b at tx_start, expected 0", tx_busy);
        end
        checks++;
        if (prev_start) begin
          errors++;
          $display("FAIL start_width: tx_start high 2 cycles in a row, expected 1");
        end
        if (seen_busy) begin
          // Last busy-high sample, then 2 idle cycles, then tx_start.
          checks++;
          if (cyc - last_busy_cyc < 3) begin
            errors++;
            $display("FAIL start_gap: %0d cycles since busy, expected >= 3", cyc - last_busy_cyc);
          end
        end
      end
      if (tx_busy === 1'b1) begin
        last_busy_cyc = cyc;
        seen_busy = 1'b1;
      end
      prev_start = (tx_start === 1'b1);
    end
  end

  // Stimulus helper: one push, ends 1 unit after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input bit expect_acc);
    in_valid = 1'b1;
    in_data  = b;
    if (expect_acc) sb.push_back(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait until the scoreboard is empty and the link has been quiet.
  task automatic drain(input string name);
    int quiet;
    bit done;
    quiet = 0;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && count == 0 && tx_busy == 1'b0 && tx_start == 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 6) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still expected, count=%0d, expected 0", name, sb.size(), count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count: %0d, expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: %b, expected 1", in_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: %b, expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: %02h, expected 00", tx_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: %b, expected 0", overflow); end
    checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL reset_timeout: %b, expected 0", timeout); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int s0, n, first_c, push_edge;
    bit bad;
    busy_len = 20;
    s0 = start_cnt;
    push_byte(8'h55, 1'b1);
    push_edge = cyc;
    n = 0;
    first_c = -1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        n++;
        if (first_c < 0) first_c = cyc;
      end
      if (tx_busy === 1'b1 && tx_data !== 8'h55) bad = 1'b1;
    end
    // Push on edge N; tx_start occupies the cycle ending at edge N+2.
    checks++; if (first_c != push_edge + 1) begin errors++; $display("FAIL single_latency: start after edge %0d, expected %0d", first_c, push_edge + 1); end
    checks++; if (n != 1) begin errors++; $display("FAIL single_starts: %0d, expected 1", n); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL single_start_cnt: %0d, expected 1", start_cnt - s0); end
    checks++; if (bad) begin errors++; $display("FAIL single_data_hold: tx_data changed during frame, expected 55"); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count: %0d, expected 0", count); end
    $display("test_single done");
  endtask

  // The first byte launches and its frame is held busy for a long time.
  // The next 16 bytes then fill the FIFO.
  task automatic test_burst();
    busy_len = 40;
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) begin
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL burst_count15: %0d, expected 15", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL burst_ready15: %b, expected 1", in_ready); end
      end
      push_byte(8'(i), 1'b1);
    end
    busy_len = 3;
    @(negedge clk);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL burst_count: %0d, expected 16", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL burst_in_ready: %b, expected 0", in_ready); end
    $display("test_burst filled");
  endtask

  task automatic test_overflow();
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = 8'hAA;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: %b, expected 0", overflow); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: %b, expected 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: %0d, expected 16", count); end
    // Clear and set in the same cycle: set wins.
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = 8'hAB;
    err_clr = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: %b, expected 1", overflow); end
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: %b, expected 0", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count2: %0d, expected 16", count); end
    drain("overflow");
    $display("test_overflow done");
  endtask

  task automatic test_timeout();
    int s0;
    bit found;
    auto_busy = 1'b0;
    push_byte(8'h3C, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL tmo_start: no tx_start within 10 cycles, expected 1"); end
    s0 = start_cnt;
    repeat (TMO) @(negedge clk);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: %b, expected 0", timeout); end
    @(negedge clk);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_set: %b, expected 1", timeout); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL tmo_count: %0d, expected 0", count); end
    repeat (20) @(negedge clk);
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL tmo_retry: %0d extra starts, expected 0", start_cnt - s0); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: %b, expected 1", timeout); end
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: %b, expected 0", timeout); end
    auto_busy = 1'b1;
    $display("test_timeout done");
  endtask

  // Hold occupancy near 4. The bench pushes on the edge two cycles after
  // tx_busy falls, which is the edge that pops the next byte.
  task automatic test_wrap();
    int pushes, coinc, prev_cnt, low_run, exp_cnt;
    bit have_prev, prev_push, do_push, seen4;
    logic [7:0] b;
    busy_len = 2;
    pushes = 0;
    coinc = 0;
    low_run = 0;
    have_prev = 1'b0;
    prev_push = 1'b0;
    seen4 = 1'b0;
    b = 8'h80;
    @(negedge clk);
    for (int i = 0; i < 1000 && (pushes < 40 || prev_push); i++) begin
      if (have_prev) begin
        exp_cnt = prev_cnt + int'(prev_push) - int'(tx_start === 1'b1);
        checks++;
        if (count !== 5'(exp_cnt)) begin
          errors++;
          $display("FAIL wrap_count: %0d, expected %0d", count, exp_cnt);
        end
        if (prev_push && tx_start === 1'b1) coinc++;
      end
      if (count == 5'd4) seen4 = 1'b1;
      if (seen4 && (count < 5'd3 || count > 5'd5)) begin
        checks++;
        errors++;
        $display("FAIL wrap_range: count=%0d, expected 3..5", count);
      end
      low_run = (tx_busy === 1'b1) ? 0 : low_run + 1;
      do_push = (pushes < 40) && ((count < 5'd4) || (low_run == 2));
      prev_cnt = int'(count);
      prev_push = do_push;
      have_prev = 1'b1;
      in_valid = do_push;
      if (do_push) begin
        in_data = b;
        sb.push_back(b);
        b = b + 8'h01;
        pushes++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (pushes != 40) begin errors++; $display("FAIL wrap_pushes: %0d, expected 40", pushes); end
    checks++; if (coinc < 10) begin errors++; $display("FAIL wrap_coincide: %0d push+pop edges, expected >= 10", coinc); end
    drain("wrap");
    $display("test_wrap done: %0d coincident push/pop edges", coinc);
  endtask

  task automatic test_mid_reset();
    int s0;
    bit found;
    busy_len = 30;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mrst_busy: tx_busy never rose, expected 1"); end
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL mrst_queued: %0d, expected 4", count); end
    s0 = start_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL mrst_count: %0d, expected 0", count); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mrst_tx_start: %b, expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mrst_tx_data: %02h, expected 00", tx_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready: %b, expected 1", in_ready); end
    repeat (60) @(negedge clk);
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL mrst_no_start: %0d starts after reset, expected 0", start_cnt - s0); end
    $display("test_mid_reset done");
  endtask

`ifdef UART_TXQ_PAUSE_EN
  task automatic test_pause();
    int s0;
    busy_len = 3;
    s0 = start_cnt;
    tx_pause = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(8'hD0 + 8'(i), 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL pause_hold: %0d starts, expected 0", start_cnt - s0); end
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL pause_count: %0d, expected 3", count); end
    tx_pause = 1'b0;
    drain("pause");
    checks++; if (start_cnt - s0 != 3) begin errors++; $display("FAIL pause_release: %0d starts, expected 3", start_cnt - s0); end
    $display("test_pause done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_wrap();
    test_mid_reset();
`ifdef UART_TXQ_PAUSE_EN
    test_pause();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
